// File: rtl/key_event_tx_queue.sv
// PS/2 make/break decoder with modifier tracking, feeding a byte FIFO that is
// drained into a UART transmitter over a level request/busy handshake.
`timescale 1ns/1ps
module key_event_tx_queue #(
  parameter int DEPTH       = 8,
  parameter int DROP_REPEAT = 1,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          key_valid,
  input  logic [15:0]   keycode,
  output logic [7:0]    map_code,
  output logic          map_shift,
  output logic          map_caps,
  output logic          map_thai,
  input  logic [7:0]    map_char,
  input  logic          manual_req,
  input  logic [7:0]    manual_data,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_busy,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          shift,
  output logic          caps_lock,
  output logic          thai_mode
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, BUSY = 2'd2} state_t;

  state_t        state, state_next;
  logic          busy_s1, busy_sync;
  logic          start_next;
  logic [7:0]    data_next;
  logic          pop;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          lshift, rshift, caps_held, lang_held;
  logic [7:0]    last_make;
  logic          last_valid;
  logic          pend;
  logic [7:0]    pend_data;

  logic          is_break, is_prefix, is_make, is_mod, is_repeat;
  logic          key_accept, key_push, push, do_push;
  logic [7:0]    code, push_data;

  assign code      = keycode[7:0];
  assign map_code  = code;
  assign shift     = lshift | rshift;
  assign map_shift = shift;
  assign map_caps  = caps_lock;
  assign map_thai  = thai_mode;

  // Key classification and enqueue arbitration (key byte wins over manual byte)
  always_comb begin
    is_break   = key_valid && (keycode[15:8] == 8'hF0);
    is_prefix  = (code == 8'hF0) || (code == 8'hE0);
    is_make    = key_valid && !is_break && !is_prefix;
    is_mod     = (code == 8'h12) || (code == 8'h59) || (code == 8'h58) || (code == 8'h0E);
    is_repeat  = (DROP_REPEAT != 0) && last_valid && (code == last_make);
    key_accept = is_make && !is_mod && !is_repeat;
    key_push   = key_accept && (map_char != 8'h00);
    push       = key_push || pend;
    push_data  = key_push ? map_char : pend_data;
    do_push    = push && (count != FULL_COUNT);
  end

  // Modifier, repeat-filter and manual-pending state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lshift <= 1'b0; rshift <= 1'b0; caps_held <= 1'b0; lang_held <= 1'b0;
      caps_lock <= 1'b0; thai_mode <= 1'b0;
      last_make <= 8'h00; last_valid <= 1'b0;
      pend <= 1'b0; pend_data <= 8'h00;
    end else begin
      if (is_break) begin
        if (code == 8'h12) lshift <= 1'b0;
        if (code == 8'h59) rshift <= 1'b0;
        if (code == 8'h58) caps_held <= 1'b0;
        if (code == 8'h0E) lang_held <= 1'b0;
        if (code == last_make) last_valid <= 1'b0;
      end else if (is_make) begin
        if (code == 8'h12) lshift <= 1'b1;
        if (code == 8'h59) rshift <= 1'b1;
        if (code == 8'h58) begin
          if (!caps_held) caps_lock <= ~caps_lock;
          caps_held <= 1'b1;
        end
        if (code == 8'h0E) begin
          if (!lang_held) thai_mode <= ~thai_mode;
          lang_held <= 1'b1;
        end
        if (key_accept) begin
          last_make  <= code;
          last_valid <= 1'b1;
        end
      end
      // A new request re-arms pend even if the previous byte leaves this cycle
      if (manual_req) begin
        pend      <= 1'b1;
        pend_data <= manual_data;
      end else if (pend && !key_push) begin
        pend <= 1'b0;
      end
    end
  end

  // FIFO storage; contents are don't-care while unoccupied
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0; rd_ptr <= '0; count <= '0; overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push && (count == FULL_COUNT)) overflow <= 1'b1;
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(pop);
    end
  end

  // tx_busy synchroniser and TX FSM registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_s1 <= 1'b0; busy_sync <= 1'b0;
      state <= IDLE; tx_start <= 1'b0; tx_data <= 8'h00;
    end else begin
      busy_s1   <= tx_busy;
      busy_sync <= busy_s1;
      state     <= state_next;
      tx_start  <= start_next;
      tx_data   <= data_next;
    end
  end

  // TX FSM next state; the popped head byte is latched into tx_data
  always_comb begin
    state_next = state;
    start_next = tx_start;
    data_next  = tx_data;
    pop        = 1'b0;
    case (state)
      IDLE: if ((count != '0) && !busy_sync) begin
        pop        = 1'b1;
        start_next = 1'b1;
        data_next  = mem[rd_ptr];
        state_next = REQ;
      end
      REQ: if (busy_sync) begin
        start_next = 1'b0;
        state_next = BUSY;
      end
      BUSY: if (!busy_sync) state_next = IDLE;
      default: begin
        state_next = IDLE;
        start_next = 1'b0;
      end
    endcase
  end

endmodule
